// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the sequential divider (seq_divider).
//   div_state_t   : controller states IDLE -> RUN -> FIN
//   DIV_W_DEFAULT : default operand width
//   DIV_W_MAX     : widest operand abs_mag() can handle
//   abs_mag()     : magnitude of a (sign-extended) operand
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } div_state_t;

  localparam int DIV_W_DEFAULT = 8;
  localparam int DIV_W_MAX     = 64;

  // The caller sign-extends (signed mode) or zero-extends (unsigned mode) the
  // operand to DIV_W_MAX bits. Negating at this width means |MIN| of a narrow
  // operand comes out as 2**(WIDTH-1), which fits WIDTH bits as an unsigned
  // magnitude.
  function automatic logic [DIV_W_MAX-1:0] abs_mag(input logic [DIV_W_MAX-1:0] value,
                                                   input logic                 is_signed);
    return (is_signed && value[DIV_W_MAX-1]) ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration on unsigned magnitudes.
//   rem_in  : partial remainder (always < dvs for a nonzero divisor)
//   bit_in  : next dividend bit, MSB first
//   dvs     : divisor magnitude
//   rem_out : next partial remainder
//   q_bit   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // One extra bit keeps the shifted remainder (< 2*dvs) from overflowing; the
  // borrow out of the trial subtraction lands in diff[W].
  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, dvs};
  assign q_bit   = ~diff[W];
  assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider, one quotient bit per cycle, signed or unsigned
// per operation. start is taken only while idle; done pulses for one cycle
// WIDTH+1 cycles after the start edge and the results hold until the next done.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, is_signed        : request and operand mode (captured with start)
//   dividend, divisor       : operands (captured with start)
//   busy, done              : operation in progress / one-cycle result strobe
//   quotient, remainder     : results (truncating toward zero)
//   div_by_zero, overflow   : result flags, held like quotient
//
// Build option: define DIV_ZERO_SHORTCUT_EN to skip the iterations when the
// divisor is zero (done one cycle after start).
// -----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;      // partial remainder magnitude
  logic [WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic [WIDTH-1:0] dvd_raw_q;  // original dividend, the divide-by-zero remainder
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dz_q;
  logic             ov_q;

  logic [DIV_W_MAX-1:0] dvd_ext;
  logic [DIV_W_MAX-1:0] dvs_ext;
  logic [WIDTH-1:0]     dvd_mag;
  logic [WIDTH-1:0]     dvs_mag;
  logic                 dvs_zero;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_q;

  assign dvs_zero = (divisor == '0);
  assign busy     = (state != IDLE);

  // Operand magnitudes at capture time.
  always_comb begin
    if (is_signed) begin
      dvd_ext = DIV_W_MAX'(signed'(dividend));
      dvs_ext = DIV_W_MAX'(signed'(divisor));
    end else begin
      dvd_ext = DIV_W_MAX'(dividend);
      dvs_ext = DIV_W_MAX'(divisor);
    end
    dvd_mag = WIDTH'(abs_mag(dvd_ext, is_signed));
    dvs_mag = WIDTH'(abs_mag(dvs_ext, is_signed));
  end

  div_step #(.W(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the next-state default comes first so no path through the case
  // leaves state_nxt unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_SHORTCUT_EN
          state_nxt = dvs_zero ? FIN : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN:     if (cnt == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the working registers are reset along with the outputs; there are
  // only a handful, and it keeps every register free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= CNT_W'(WIDTH - 1);
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            dvd_raw_q <= dividend;
            q_neg_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_q   <= is_signed & dividend[WIDTH-1];
            dz_q      <= dvs_zero;
            ov_q      <= is_signed & (dividend == MIN_VAL) & (divisor == '1);
          end
        end
        RUN: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[WIDTH-2:0], step_q};
          cnt   <= cnt - 1'b1;
        end
        FIN: begin
          // MIN / -1 needs no special case: the magnitude 2**(WIDTH-1) with a
          // positive sign already reads back as MIN.
          done        <= 1'b1;
          quotient    <= dz_q ? '1        : (q_neg_q ? -quo_q : quo_q);
          remainder   <= dz_q ? dvd_raw_q : (r_neg_q ? -rem_q : rem_q);
          div_by_zero <= dz_q;
          overflow    <= ov_q & ~dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised, iterative, multi-cycle integer divider; successor to the team's combinational 8-bit divider.
- Handles signed or unsigned operands, selected per operation.
- Produces quotient and remainder, and flags divide-by-zero and signed overflow.
- Sits behind the ALU opcode decoder; uses a start/busy/done handshake so division no longer sets the ALU critical path.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits (minimum 2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a division; sampled only when busy=0.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- dividend  input  WIDTH  numerator; captured with start.
- divisor  input  WIDTH  denominator; captured with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  result quotient, held until the next done.
- remainder  output  WIDTH  result remainder, held until the next done.
- div_by_zero  output  1  last result had divisor=0; held like quotient.
- overflow  output  1  last result was signed MIN / -1; held like quotient.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - busy, done, div_by_zero, overflow, quotient, remainder all 0.
  - Takes effect immediately, including mid-operation. The in-flight operation is discarded and no done is produced.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge E0: capture is_signed and operands, store absolute values (signed mode) and result sign bits.
  - Load counter = WIDTH-1; go to RUN; busy=1 after E0.
- RUN: one restoring step per cycle.
  - Shift partial remainder left, bring in the next dividend MSB, trial-subtract |divisor|, set the quotient bit.
  - Counter decrements; after the step with counter=0, go to FIN.
  - This is WIDTH cycles, edges E1..E_WIDTH.
- FIN (edge E_WIDTH+1):
  - Apply sign correction and register quotient, remainder and flags.
  - busy falls and done rises on the same edge; state returns to IDLE.
  - done falls at edge E_WIDTH+2.
  - Total latency: start edge to done = WIDTH+1 cycles.
- Throughput / back-to-back:
  - start is accepted in the cycle done is high (busy=0). The new operation starts at the next edge.
  - start while busy=1 is ignored. Operands changing while busy do not affect the result.
- Arithmetic:
  - Truncation toward zero.
  - Quotient negative iff operand signs differ (signed mode only).
  - Remainder sign follows the dividend; |remainder| < |divisor|.
  - Absolute value of MIN is handled as an unsigned magnitude on WIDTH bits, with no extra sign bit lost.
- Divide-by-zero (divisor=0):
  - quotient = all ones, remainder = dividend, div_by_zero=1, overflow=0.
  - Normal latency applies unless the optional feature below is enabled.
- Signed overflow (is_signed=1, dividend=MIN, divisor=-1):
  - quotient = MIN, remainder = 0, overflow=1.
  - Same latency as a normal operation.
- Flags are cleared on the done edge of any operation that does not raise them.

Optional Feature:
- Macro: DIV_ZERO_SHORTCUT_EN.
- Defined: divisor=0 at start goes IDLE -> FIN directly.
  - done rises at E1; busy is high for exactly one cycle.
  - Results as defined above.
- Undefined: divide-by-zero runs the full WIDTH iterations; latency WIDTH+1.
- All other behaviour is identical with and without the macro.

Decomposition:
- Package div_pkg holds:
  - state enum div_state_t {IDLE, RUN, FIN};
  - default width constant DIV_W_DEFAULT = 8;
  - helper function abs_mag(value, is_signed).
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, |divisor|.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once in seq_divider.

Test Plan:
- WIDTH=8, signed, -128/2 (0x80/0x02) -> done at start+9 cycles; quotient 0xC0, remainder 0x00, flags 0.
- Signed, -128/7 -> quotient 0xEE (-18), remainder 0xFE (-2).
- Signed, -7/2 (0xF9/0x02) -> quotient 0xFD (-3), remainder 0xFF (-1).
- Unsigned 200/7 (0xC8/0x07) -> quotient 28 (0x1C), remainder 4; back-to-back with signed 64/7 started in the done cycle -> quotient 9, remainder 1, done exactly 9 cycles later.
- 37/0 -> quotient 0xFF, remainder 37, div_by_zero=1; latency 9 cycles without DIV_ZERO_SHORTCUT_EN, 1 cycle with it.
- Signed -128/-1 -> quotient 0x80, remainder 0, overflow=1.
- Separately: pull rst_n low at cycle 4 of an operation -> all outputs 0 immediately, no done pulse.
- Separately: start asserted while busy is ignored.
